sram_port0_arbiter: RTL and testbench
=====================================

# sram_port0_arbiter

Sequencer and two-way arbiter for read/write port 0 of the 2 kB OpenRAM program store (32 bits x 512 words). It shares that port between the Caravel Wishbone slave and an internal requester such as a boot loader or debug engine. It drives csb0/web0/addr0/din0/wmask0, absorbs the SRAM's one-cycle read latency, and returns a Wishbone ack or an internal done pulse. Port 1, the CPU fetch port, is not touched.

## Interface
- ADDR_BASE, 21'h180000: match value for wbs_adr_i[31:11]; the window is 2 kB.
- wb_clk_i  in  1  clock; every register is on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobe and direction.
- wbs_adr_i  in  32  byte address; bits [10:2] are the word address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte lanes.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data; valid while wbs_ack_o=1.
- req_valid  in  1  internal request; held until req_done.
- req_we  in  1  internal direction; 1 = write.
- req_addr  in  9  internal word address.
- req_wdata  in  32  internal write data.
- req_wmask  in  4  internal byte lanes.
- req_done  out  1  one-cycle completion pulse.
- req_rdata  out  32  internal read data; valid while req_done=1.
- sram_csb  out  1  to csb0, active-low.
- sram_web  out  1  to web0, active-low.
- sram_addr  out  9  to addr0.
- sram_din  out  32  to din0.
- sram_wmask  out  4  to wmask0.
- sram_dout  in  32  from dout0.
- busy  out  1  high in every state except IDLE.

## Operation
- Wishbone request (wb_req) = cyc & stb & (wbs_adr_i[31:11]==ADDR_BASE). If the address does not match, the block ignores the cycle and never acks it.
- States:
  - IDLE: waits for a request.
  - ISSUE: SRAM enable cycle.
  - READ: captures dout.
  - ACK: completion cycle.
- IDLE: if only one requester is active, it is granted. If both are active, the requester not granted last time wins (1-bit last_grant). On grant, register sram_addr, sram_din, sram_wmask (all ones for reads), sram_web = ~we and sram_csb = 0, then go to ISSUE.
- ISSUE: SRAM outputs are stable and the SRAM samples at the end of this cycle. Next state: sram_csb=1 and sram_web=1. A read goes to READ; a write goes to ACK.
- READ: capture sram_dout into the grantee's data register, then go to ACK.
- ACK: assert wbs_ack_o or req_done for the grantee, then go to IDLE.
- Grants are non-preemptive; one transaction is outstanding at a time.
- If wbs_cyc_i drops after grant, the SRAM operation still completes and the ack is suppressed. last_grant still updates.
- A write with wbs_sel_i=0 still runs and acks, with wmask 0 (memory is unchanged).
- wbs_dat_o and req_rdata hold their last captured value outside ACK.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, req_done=0, req_rdata=0, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, sram_wmask=0, busy=0, state=IDLE, last_grant=internal (so Wishbone wins the first tie).
- Reset asserted mid-transaction: sram_csb and sram_web go to 1 immediately (asynchronous). No ack or done is issued for the aborted transaction.
- The request is sampled in IDLE at cycle N:
  - ISSUE is cycle N+1.
  - Write: ack/done in cycle N+2 (latency 2).
  - Read: READ is cycle N+2, ack/done in cycle N+3 (latency 3).
- Back-to-back: the next grant is sampled in the ACK cycle's following IDLE. Throughput is one write per 3 cycles, one read per 4.
- Wishbone holding stb through its ack cycle must not be re-granted: IDLE ignores wb_req in the cycle right after a Wishbone ack.
- Simultaneous requests repeated: grants alternate strictly between Wishbone and internal.

## Test plan
- After reset, Wishbone writes 0xDEADBEEF, sel=4'hF, to address ADDR_BASE<<11 | 0x010:
  - in ISSUE: sram_addr=4, sram_web=0, sram_wmask=F;
  - ack 2 cycles after the request.
  - Then read the same address: sram_web=1, ack at +3, wbs_dat_o=0xDEADBEEF.
- Internal read of address 9 while the SRAM model holds 0x12345678: req_done pulses at +3 and req_rdata=0x12345678. wbs_ack_o stays 0 throughout.
- Wishbone and internal requests asserted together, held, three times: grant order is Wishbone, internal, Wishbone. busy stays high except for the single IDLE cycle between transactions.
- Wishbone access to a non-matching address 0x3000_0000: sram_csb stays 1, no ack, busy stays 0.
- Wishbone read granted, cyc dropped in ISSUE: the SRAM read completes, wbs_ack_o is never asserted, and the state is back in IDLE at +4.
- wb_rst_i pulsed during ISSUE of a write: sram_csb=1 and sram_web=1 in the same cycle, no ack, all outputs at their reset values. A new request after reset completes normally.

Source files
------------

// File: rtl/sram_port0_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port0_arbiter
//  Description : Sequencer and two-way arbiter for read/write port 0 of the
//                2 kB OpenRAM program store (32 bits x 512 words). Port 0 is
//                shared between the Caravel Wishbone slave and an internal
//                requester (boot loader / debug engine). The block absorbs the
//                SRAM's one-cycle read latency and returns a Wishbone ack or an
//                internal done pulse.
//  Ports       :
//    wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//    wbs_cyc_i/stb_i/we_i      Wishbone classic strobe and direction
//    wbs_adr_i/dat_i/sel_i     byte address, write data, byte lanes
//    wbs_ack_o/dat_o           one-cycle ack, read data valid with ack
//    req_valid/we/addr/wdata/wmask  internal request, held until req_done
//    req_done/req_rdata        one-cycle done, read data valid with done
//    sram_csb/web/addr/din/wmask    to OpenRAM port 0 (csb0/web0/...)
//    sram_dout                 from OpenRAM dout0
//    busy                      high in every state except IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port0_arbiter #(
    parameter logic [20:0] ADDR_BASE = 21'h180000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [8:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        req_done,
    output logic [31:0] req_rdata,
    output logic        sram_csb,
    output logic        sram_web,
    output logic [8:0]  sram_addr,
    output logic [31:0] sram_din,
    output logic [3:0]  sram_wmask,
    input  logic [31:0] sram_dout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_READ  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic c_GNT_WB  = 1'b0;
    localparam logic c_GNT_INT = 1'b1;

    state_t      r_state;
    logic        r_grant;       // owner of the transaction in flight
    logic        r_last_grant;  // loser of the last tie wins the next one
    logic        r_skip_wb;     // masks a Wishbone strobe still held over its ack
    logic        r_we;
    logic        r_wb_ack;
    logic [31:0] r_wb_dat;
    logic        r_req_done;
    logic [31:0] r_req_rdata;
    logic        r_sram_csb;
    logic        r_sram_web;
    logic [8:0]  r_sram_addr;
    logic [31:0] r_sram_din;
    logic [3:0]  r_sram_wmask;

    logic        w_wb_req;
    logic        w_pick_int;
    logic        w_sel_we;
    logic        w_unused_bits;

    assign w_unused_bits = &{1'b0, wbs_adr_i[1:0]};

    assign w_wb_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:11] == ADDR_BASE) & ~r_skip_wb;
    // On a tie the requester not granted last time wins.
    assign w_pick_int = (w_wb_req & req_valid) ? ~r_last_grant : req_valid;
    assign w_sel_we   = w_pick_int ? req_we : wbs_we_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_grant      <= c_GNT_WB;
            r_last_grant <= c_GNT_INT;
            r_skip_wb    <= 1'b0;
            r_we         <= 1'b0;
            r_wb_ack     <= 1'b0;
            r_wb_dat     <= 32'h0;
            r_req_done   <= 1'b0;
            r_req_rdata  <= 32'h0;
            r_sram_csb   <= 1'b1;
            r_sram_web   <= 1'b1;
            r_sram_addr  <= 9'h0;
            r_sram_din   <= 32'h0;
            r_sram_wmask <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_skip_wb <= 1'b0;
                    if (w_wb_req | req_valid) begin
                        r_grant      <= w_pick_int;
                        r_last_grant <= w_pick_int;
                        r_we         <= w_sel_we;
                        r_sram_addr  <= w_pick_int ? req_addr : wbs_adr_i[10:2];
                        r_sram_din   <= w_pick_int ? req_wdata : wbs_dat_i;
                        r_sram_wmask <= w_sel_we ? (w_pick_int ? req_wmask : wbs_sel_i) : 4'hF;
                        r_sram_web   <= ~w_sel_we;
                        r_sram_csb   <= 1'b0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // SRAM samples at the end of this cycle; release it afterwards.
                    r_sram_csb <= 1'b1;
                    r_sram_web <= 1'b1;
                    if (r_we) begin
                        // An abandoned Wishbone cycle still completes, unacked.
                        r_wb_ack   <= (r_grant == c_GNT_WB) & wbs_cyc_i;
                        r_req_done <= (r_grant == c_GNT_INT);
                        r_state    <= S_ACK;
                    end else begin
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_grant == c_GNT_INT) begin
                        r_req_rdata <= sram_dout;
                    end else begin
                        r_wb_dat    <= sram_dout;
                    end
                    r_wb_ack   <= (r_grant == c_GNT_WB) & wbs_cyc_i;
                    r_req_done <= (r_grant == c_GNT_INT);
                    r_state    <= S_ACK;
                end
                default: begin // S_ACK
                    r_wb_ack   <= 1'b0;
                    r_req_done <= 1'b0;
                    r_skip_wb  <= (r_grant == c_GNT_WB);
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o  = r_wb_ack;
    assign wbs_dat_o  = r_wb_dat;
    assign req_done   = r_req_done;
    assign req_rdata  = r_req_rdata;
    assign sram_csb   = r_sram_csb;
    assign sram_web   = r_sram_web;
    assign sram_addr  = r_sram_addr;
    assign sram_din   = r_sram_din;
    assign sram_wmask = r_sram_wmask;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sram_port0_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port0_arbiter
//  Description : Self-checking bench for sram_port0_arbiter. Stimulus pushes
//                the expected completion (source, data, cycle) into a queue;
//                a monitor pops and compares on every ack / done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_port0_arbiter;

    localparam logic [20:0] c_BASE = 21'h180000;
    localparam logic [31:0] c_WIN  = {c_BASE, 11'h0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [8:0]  req_addr = 9'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wmask = 4'h0;
    logic        req_done;
    logic [31:0] req_rdata;
    logic        sram_csb, sram_web;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_dout;
    logic        busy;

    sram_port0_arbiter #(.ADDR_BASE(c_BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .req_done(req_done), .req_rdata(req_rdata),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_wmask(sram_wmask), .sram_dout(sram_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural OpenRAM port 0: registered read, byte-masked write.
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
        end
    endtask

    typedef struct {
        bit          src;   // 0 = Wishbone, 1 = internal
        bit          chk_d;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    // Monitor: every ack/done must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst && (wbs_ack_o || req_done)) begin
            exp_t e;
            chk("ack_and_done_exclusive", {31'h0, wbs_ack_o & req_done}, 32'h0);
            if (q.size() == 0) begin
                chk("unexpected_completion", {31'h0, wbs_ack_o}, {31'h0, 1'b0});
            end else begin
                e = q.pop_front();
                chk("completion_source", {31'h0, req_done}, {31'h0, e.src});
                chk("completion_cycle", cnt, e.due);
                if (e.chk_d)
                    chk("completion_data", e.src ? req_rdata : wbs_dat_o, e.data);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"},   {31'h0, wbs_ack_o}, 32'h0);
        chk({tag, "_dato"},  wbs_dat_o, 32'h0);
        chk({tag, "_done"},  {31'h0, req_done}, 32'h0);
        chk({tag, "_rdata"}, req_rdata, 32'h0);
        chk({tag, "_csb"},   {31'h0, sram_csb}, 32'h1);
        chk({tag, "_web"},   {31'h0, sram_web}, 32'h1);
        chk({tag, "_addr"},  {23'h0, sram_addr}, 32'h0);
        chk({tag, "_din"},   sram_din, 32'h0);
        chk({tag, "_wmask"}, {28'h0, sram_wmask}, 32'h0);
        chk({tag, "_busy"},  {31'h0, busy}, 32'h0);
    endtask

    // Wishbone transfer with ISSUE-cycle port checks and a bounded ack wait.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp_rd);
        exp_t e;
        bit   got;
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        e.src = 1'b0; e.chk_d = ~we; e.data = exp_rd; e.due = cnt + (we ? 2 : 3);
        q.push_back(e);
        @(negedge clk);
        chk("wb_issue_csb",   {31'h0, sram_csb}, 32'h0);
        chk("wb_issue_web",   {31'h0, sram_web}, {31'h0, ~we});
        chk("wb_issue_addr",  {23'h0, sram_addr}, {23'h0, adr[10:2]});
        chk("wb_issue_wmask", {28'h0, sram_wmask}, {28'h0, we ? sel : 4'hF});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) got = 1'b1;
        end
        chk("wb_ack_timeout", {31'h0, got}, 32'h1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic int_xfer(input logic we, input logic [8:0] a, input logic [31:0] d,
                            input logic [3:0] m, input logic [31:0] exp_rd);
        exp_t e;
        bit   got;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        e.src = 1'b1; e.chk_d = ~we; e.data = exp_rd; e.due = cnt + (we ? 2 : 3);
        q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (req_done) got = 1'b1;
        end
        chk("int_done_timeout", {31'h0, got}, 32'h1);
        req_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c0;

        // ---- reset ----
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // ---- Wishbone write / read of word 4 ----
        wb_xfer(1'b1, c_WIN | 32'h010, 32'hDEADBEEF, 4'hF, 32'h0);
        wb_xfer(1'b0, c_WIN | 32'h010, 32'h0, 4'h0, 32'hDEADBEEF);
        // sel=0 write runs and acks but leaves memory untouched
        wb_xfer(1'b1, c_WIN | 32'h010, 32'h11111111, 4'h0, 32'h0);
        wb_xfer(1'b0, c_WIN | 32'h010, 32'h0, 4'h0, 32'hDEADBEEF);

        // ---- internal write then read of word 9 ----
        int_xfer(1'b1, 9'd9, 32'h12345678, 4'hF, 32'h0);
        int_xfer(1'b0, 9'd9, 32'h0, 4'h0, 32'h12345678);

        // ---- simultaneous held requests: WB, internal, WB ----
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = c_WIN | 32'h020; wbs_dat_i = 32'hA5A5A5A5; wbs_sel_i = 4'hF;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'd5; req_wdata = 32'h5A5A5A5A; req_wmask = 4'hF;
        c0 = cnt;
        e.chk_d = 1'b0; e.data = 32'h0;
        e.src = 1'b0; e.due = c0 + 2; q.push_back(e);
        e.src = 1'b1; e.due = c0 + 5; q.push_back(e);
        e.src = 1'b0; e.due = c0 + 8; q.push_back(e);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("arb_busy", {31'h0, busy}, {31'h0, !(k == 3 || k == 6)});
            if (k == 5) req_valid = 1'b0;
            if (k == 8) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
        end
        wb_xfer(1'b0, c_WIN | 32'h020, 32'h0, 4'h0, 32'hA5A5A5A5);
        int_xfer(1'b0, 9'd5, 32'h0, 4'h0, 32'h5A5A5A5A);

        // ---- non-matching address is ignored ----
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'hFFFFFFFF; wbs_sel_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("miss_csb",  {31'h0, sram_csb}, 32'h1);
            chk("miss_busy", {31'h0, busy}, 32'h0);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

        // ---- Wishbone read abandoned in ISSUE ----
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = c_WIN | 32'h010;
        @(negedge clk);
        chk("drop_issue_csb", {31'h0, sram_csb}, 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        chk("drop_sram_read", sram_dout, 32'hDEADBEEF);
        chk("drop_busy_read", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("drop_busy_ack", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("drop_idle", {31'h0, busy}, 32'h0);

        // ---- reset pulse during ISSUE of a write ----
        repeat (3) @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = c_WIN | 32'h040; wbs_dat_i = 32'hCAFEF00D; wbs_sel_i = 4'hF;
        @(negedge clk);
        chk("rst_issue_csb", {31'h0, sram_csb}, 32'h0);
        #2 rst = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        #1 check_reset_vals("midrst");
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mem_untouched", {31'h0, mem[16] === 32'hCAFEF00D}, 32'h0);
        wb_xfer(1'b1, c_WIN | 32'h040, 32'h0BADF00D, 4'hF, 32'h0);
        wb_xfer(1'b0, c_WIN | 32'h040, 32'h0, 4'h0, 32'h0BADF00D);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
